// File: rtl/hazard_ctrl_pkg.sv
//------------------------------------------------------------------------------
// hazard_ctrl_pkg : shared CPU constants for pipeline hazard control
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package hazard_ctrl_pkg;

  localparam logic [1:0] ST_RUN        = 2'd0;
  localparam logic [1:0] ST_LOAD_STALL = 2'd1;
  localparam logic [1:0] ST_MC_WAIT    = 2'd2;
  localparam logic [1:0] ST_FLUSH      = 2'd3;

  localparam logic [4:0] REG_ZERO      = 5'd0;
  localparam logic [4:0] MC_MIN_CYCLES = 5'd2;

  // A load result can only be forwarded late, so any ID read of its rd stalls.
  function automatic logic load_use(input logic       ld,
                                    input logic [4:0] rd,
                                    input logic       use1,
                                    input logic [4:0] rs1,
                                    input logic       use2,
                                    input logic [4:0] rs2);
    return ld && (rd != REG_ZERO) &&
           ((use1 && (rs1 == rd)) || (use2 && (rs2 == rd)));
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl.sv
//------------------------------------------------------------------------------
// hazard_ctrl : stall/flush sequencer for load-use, multi-cycle EX and branches
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_load,
  input  logic        ex_branch_taken,
  input  logic        ex_mc_start,
  input  logic [4:0]  ex_mc_cycles,
  output logic        pc_en,
  output logic        s1_en,
  output logic        s2_en,
  output logic        s3_en,
  output logic        s1_flush_n,
  output logic        s2_flush_n,
  output logic [31:0] stall_cnt
);

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] stall_cnt_q;
  logic        pc_en_w, s1_en_w, s2_en_w, s3_en_w;
  logic        hazard_w;

  assign hazard_w = load_use(ex_load, ex_rd, id_use_rs1, id_rs1, id_use_rs2, id_rs2);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_en_w = 1'b1;
    s1_en_w = 1'b1;
    s2_en_w = 1'b1;
    s3_en_w = 1'b1;
    case (state_q)
      ST_RUN: begin
        if (ex_branch_taken) begin
          state_d = ST_FLUSH;
        end else if (ex_mc_start && (ex_mc_cycles >= MC_MIN_CYCLES)) begin
          {pc_en_w, s1_en_w, s2_en_w, s3_en_w} = 4'b0000;
          cnt_d   = ex_mc_cycles - 5'd1;
          state_d = ST_MC_WAIT;
        end else if (hazard_w) begin
          {pc_en_w, s1_en_w, s2_en_w} = 3'b000;
          state_d = ST_LOAD_STALL;
        end
      end
      ST_LOAD_STALL: begin
        {pc_en_w, s1_en_w, s2_en_w} = 3'b000;
        state_d = ST_RUN;
      end
      ST_MC_WAIT: begin
        // The final count releases all stages so EX/MEM captures N cycles in.
        if (cnt_q > 5'd1) begin
          {pc_en_w, s1_en_w, s2_en_w, s3_en_w} = 4'b0000;
          cnt_d = cnt_q - 5'd1;
        end else begin
          cnt_d   = 5'd0;
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = 5'd0;
      end
    endcase
  end

  assign pc_en      = ~rst & pc_en_w;
  assign s1_en      = ~rst & s1_en_w;
  assign s2_en      = ~rst & s2_en_w;
  assign s3_en      = ~rst & s3_en_w;
  assign s1_flush_n = ~rst & (state_q != ST_FLUSH);
  assign s2_flush_n = ~rst & (state_q != ST_FLUSH) & (state_q != ST_LOAD_STALL);
  assign stall_cnt  = stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      cnt_q       <= 5'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!pc_en_w && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
//------------------------------------------------------------------------------
// tb_hazard_ctrl : self-checking bench for hazard_ctrl
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd, ex_mc_cycles;
  logic        id_use_rs1, id_use_rs2, ex_load, ex_branch_taken, ex_mc_start;
  logic        pc_en, s1_en, s2_en, s3_en, s1_flush_n, s2_flush_n;
  logic [31:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_load(ex_load), .ex_branch_taken(ex_branch_taken),
    .ex_mc_start(ex_mc_start), .ex_mc_cycles(ex_mc_cycles),
    .pc_en(pc_en), .s1_en(s1_en), .s2_en(s2_en), .s3_en(s3_en),
    .s1_flush_n(s1_flush_n), .s2_flush_n(s2_flush_n),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each accepted event schedules its whole output sequence
  // {pc,s1,s2,s3,s1_flush_n,s2_flush_n}; new events are only looked at
  // once the schedule has drained.
  logic [5:0]  sched[$];
  logic [5:0]  exp_out;
  logic [31:0] model_cnt = 32'd0;
  bit          primed = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      sched.delete();
      exp_out = 6'b000000;
    end else begin
      if (sched.size() == 0) begin
        if (ex_branch_taken) begin
          sched.push_back(6'b111111);
          sched.push_back(6'b111100);
        end else if (ex_mc_start && ex_mc_cycles >= 2) begin
          for (int i = 0; i < int'(ex_mc_cycles) - 1; i++) sched.push_back(6'b000011);
          sched.push_back(6'b111111);
        end else if (ex_load && ex_rd != 0 &&
                     ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd))) begin
          sched.push_back(6'b000111);
          sched.push_back(6'b000110);
        end else begin
          sched.push_back(6'b111111);
        end
      end
      exp_out = sched.pop_front();
    end
    check("outputs", {26'd0, pc_en, s1_en, s2_en, s3_en, s1_flush_n, s2_flush_n},
          {26'd0, exp_out});
    if (primed) check("stall_cnt_model", stall_cnt, model_cnt);
    if (rst) begin
      model_cnt = 32'd0;
      primed    = 1'b1;
    end else if (!exp_out[5] && model_cnt != 32'hFFFF_FFFF) begin
      model_cnt = model_cnt + 1;
    end
  end

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = 5'd0; ex_load = 1'b0; ex_branch_taken = 1'b0;
    ex_mc_start = 1'b0; ex_mc_cycles = 5'd0;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (3) next();
    @(negedge clk);
    check("rst_pc_en", {31'd0, pc_en}, 32'd0);
    check("rst_flush", {30'd0, s1_flush_n, s2_flush_n}, 32'd0);
    next(); rst = 1'b0;
    @(negedge clk);
    check("post_rst_run", {26'd0, pc_en, s1_en, s2_en, s3_en, s1_flush_n, s2_flush_n}, 32'h3F);
    check("post_rst_cnt", stall_cnt, 32'd0);

    // Load-use via rs1
    next(); ex_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    @(negedge clk);
    check("lu_c1", {28'd0, pc_en, s1_en, s2_en, s2_flush_n}, 32'b0001);
    next(); idle();
    @(negedge clk);
    check("lu_c2", {28'd0, pc_en, s3_en, s1_flush_n, s2_flush_n}, 32'b0110);
    next();
    @(negedge clk);
    check("lu_done", {30'd0, pc_en, s2_flush_n}, 32'b11);
    check("lu_cnt", stall_cnt, 32'd2);

    // Load to x0 never stalls
    next(); ex_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    @(negedge clk);
    check("x0_nostall", {31'd0, pc_en}, 32'd1);

    // Load-use via rs2; unused rs1 match must not matter
    next(); idle(); ex_load = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_rs2 = 5'd9; id_use_rs2 = 1'b1;
    next(); idle();
    next(); ex_load = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9;
    @(negedge clk);
    check("unused_rs1", {31'd0, pc_en}, 32'd1);

    // Multi-cycle op N=4, with a branch attempt while waiting (ignored)
    next(); idle(); ex_mc_start = 1'b1; ex_mc_cycles = 5'd4;
    @(negedge clk);
    check("mc_c1", {28'd0, pc_en, s1_en, s2_en, s3_en}, 32'd0);
    next(); idle(); ex_branch_taken = 1'b1;
    next(); idle();
    @(negedge clk);
    check("mc_c3", {31'd0, s3_en}, 32'd0);
    next();
    @(negedge clk);
    check("mc_c4", {28'd0, pc_en, s1_en, s2_en, s3_en}, 32'hF);
    check("mc_cnt", stall_cnt, 32'd7);

    // N of 0 and 1 are single-cycle
    next(); ex_mc_start = 1'b1; ex_mc_cycles = 5'd1;
    @(negedge clk);
    check("mc1_nostall", {31'd0, pc_en}, 32'd1);
    next(); ex_mc_cycles = 5'd0;
    next(); idle();

    // Branch beats load-use
    next(); ex_branch_taken = 1'b1; ex_load = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
    @(negedge clk);
    check("br_c1", {31'd0, pc_en}, 32'd1);
    next(); idle();
    @(negedge clk);
    check("br_flush", {29'd0, pc_en, s1_flush_n, s2_flush_n}, 32'b100);
    next();
    @(negedge clk);
    check("br_done", {30'd0, s1_flush_n, s2_flush_n}, 32'b11);

    // Multi-cycle beats load-use
    next(); ex_mc_start = 1'b1; ex_mc_cycles = 5'd2; ex_load = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_use_rs1 = 1'b1;
    @(negedge clk);
    check("mc_vs_lu", {31'd0, s3_en}, 32'd0);
    next(); idle();
    next();
    @(negedge clk);
    check("mc2_cnt", stall_cnt, 32'd8);

    // Reset in the 2nd MC_WAIT cycle
    next(); ex_mc_start = 1'b1; ex_mc_cycles = 5'd4;
    next(); idle();
    next(); rst = 1'b1;
    @(negedge clk);
    check("mcrst_en", {28'd0, pc_en, s1_en, s2_en, s3_en}, 32'd0);
    check("mcrst_flush", {30'd0, s1_flush_n, s2_flush_n}, 32'd0);
    next();
    @(negedge clk);
    check("mcrst_cnt0", stall_cnt, 32'd0);
    next(); rst = 1'b0;
    @(negedge clk);
    check("mcrst_run", {26'd0, pc_en, s1_en, s2_en, s3_en, s1_flush_n, s2_flush_n}, 32'h3F);
    next();
    @(negedge clk);
    check("mcrst_cnt", stall_cnt, 32'd0);

    repeat (3) next();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
